// File: rtl/sprite_load_scheduler.sv
// Shares the sprite bitmap ROM among NUM_SLOTS renderers by granting each active
// slot a LOAD_CYCLES load window in a compacted schedule during hblank.
module sprite_load_scheduler #(
    parameter int NUM_SLOTS    = 5,
    parameter int LOAD_CYCLES  = 4,
    parameter int YOFS_W       = 4,
    parameter int HBLANK_START = 256,
    parameter int ABORT_HPOS   = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [8:0]                  hpos,
    input  logic [NUM_SLOTS-1:0]        slot_active,
    input  logic [NUM_SLOTS*YOFS_W-1:0] slot_yofs,
    output logic [NUM_SLOTS-1:0]        slot_load,
    output logic [YOFS_W-1:0]           rom_yofs,
    output logic [2:0]                  cur_slot,
    output logic                        busy,
    output logic                        done,
    output logic                        overrun
);

    localparam int CNT_W = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, LOAD, DONE} state_t;

    state_t               r_state,   w_state_nx;
    logic [NUM_SLOTS-1:0] r_pending, w_pending_nx;
    logic [2:0]           r_cur,     w_cur_nx;
    logic [CNT_W-1:0]     r_cnt,     w_cnt_nx;
    logic                 r_overrun, w_overrun_nx;

    logic                 w_trigger;
    logic                 w_abort;
    logic [2:0]           w_low;
    logic [NUM_SLOTS-1:0] w_pending_clr;
    logic                 w_found;

    assign w_trigger = (hpos == 9'(HBLANK_START));
    assign w_abort   = (hpos == 9'(ABORT_HPOS));

    // Lowest pending slot and the pending mask with that slot removed.
    always_comb begin
        w_low         = '0;
        w_found       = 1'b0;
        w_pending_clr = r_pending;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (r_pending[i] && !w_found) begin
                w_low            = 3'(i);
                w_found          = 1'b1;
                w_pending_clr[i] = 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_pending_nx = r_pending;
        w_cur_nx     = r_cur;
        w_cnt_nx     = r_cnt;
        w_overrun_nx = r_overrun;
        case (r_state)
            IDLE: begin
                if (w_trigger) begin
                    w_pending_nx = slot_active;
                    w_state_nx   = SCAN;
                end
            end
            SCAN: begin
                if (r_pending == '0) begin
                    w_state_nx = DONE;
                end else begin
                    w_cur_nx     = w_low;
                    w_pending_nx = w_pending_clr;
                    w_cnt_nx     = CNT_W'(LOAD_CYCLES - 1);
                    w_state_nx   = LOAD;
                end
            end
            LOAD: begin
                if (r_cnt == '0) w_state_nx = SCAN;
                else             w_cnt_nx   = r_cnt - 1'b1;
            end
            DONE: w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
        // Abort overrides every transition above, including DONE.
        if (r_state != IDLE && w_abort) begin
            w_state_nx   = IDLE;
            w_pending_nx = '0;
            w_overrun_nx = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_cur     <= '0;
            r_cnt     <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_pending <= w_pending_nx;
            r_cur     <= w_cur_nx;
            r_cnt     <= w_cnt_nx;
            r_overrun <= w_overrun_nx;
        end
    end

    always_comb begin
        slot_load = '0;
        rom_yofs  = slot_yofs[0 +: YOFS_W];
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (r_cur == 3'(i)) begin
                slot_load[i] = (r_state == LOAD);
                rom_yofs     = slot_yofs[i*YOFS_W +: YOFS_W];
            end
        end
    end

    assign cur_slot = r_cur;
    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);
    assign overrun  = r_overrun;

endmodule

// File: tb/tb_sprite_load_scheduler.sv
// Bench for sprite_load_scheduler: per-cycle expectations come from the schedule
// timing formula and are queued at drive time, popped and compared mid-cycle.
`timescale 1ns/1ps
module tb_sprite_load_scheduler;

    localparam int N  = 5;
    localparam int LC = 4;
    localparam int YW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [8:0]    hpos;
    logic [N-1:0]  slot_active;
    logic [N*YW-1:0] slot_yofs;
    logic [N-1:0]  slot_load;
    logic [YW-1:0] rom_yofs;
    logic [2:0]    cur_slot;
    logic          busy, done, overrun;

    sprite_load_scheduler #(
        .NUM_SLOTS(N), .LOAD_CYCLES(LC), .YOFS_W(YW),
        .HBLANK_START(256), .ABORT_HPOS(0)
    ) dut (
        .clk(clk), .reset(reset), .hpos(hpos), .slot_active(slot_active),
        .slot_yofs(slot_yofs), .slot_load(slot_load), .rom_yofs(rom_yofs),
        .cur_slot(cur_slot), .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           h;
        logic [N-1:0] load;
        logic         done;
        logic         busy;
        logic         ovr;
        logic         chk_slot;
        logic [2:0]   cur;
        logic [YW-1:0] yofs;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_load3 = 0;

    // Timing model state: a schedule triggered at cycle m_trig with m_k slots.
    bit           m_act = 0;
    int           m_trig = 0;
    int           m_k = 0;
    logic [N-1:0] m_mask = '0;
    logic         m_ovr = 1'b0;

    function automatic int nth_set(input logic [N-1:0] mask, input int j);
        int c = 0;
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                if (c == j) return i;
                c++;
            end
        end
        return 0;
    endfunction

    task automatic drive(input int h, input logic [N-1:0] act, input logic rst);
        exp_t e;
        int rel, j, off, s;
        @(posedge clk);
        #1;
        hpos = 9'(h); slot_active = act; reset = rst;
        e.h = h; e.load = '0; e.done = 1'b0; e.busy = 1'b0; e.ovr = m_ovr;
        e.chk_slot = 1'b0; e.cur = '0; e.yofs = '0;
        if (m_act) begin
            rel = cyc - m_trig;
            if (rel > 2 + (LC+1)*m_k) begin
                m_act = 0;
            end else begin
                e.busy = 1'b1;
                if (rel == 2 + (LC+1)*m_k) e.done = 1'b1;
                else if (rel >= 2) begin
                    j = (rel - 2) / (LC+1);
                    off = (rel - 2) % (LC+1);
                    if (off < LC) begin
                        s = nth_set(m_mask, j);
                        e.load[s] = 1'b1;
                        e.chk_slot = 1'b1;
                        e.cur = 3'(s);
                        e.yofs = slot_yofs[s*YW +: YW];
                    end
                end
            end
        end
        q.push_back(e);
        if (rst) begin
            m_act = 0; m_ovr = 1'b0;
        end else if (e.busy && h == 0) begin
            m_act = 0; m_ovr = 1'b1;
        end else if (!e.busy && h == 256) begin
            m_act = 1; m_trig = cyc; m_mask = act; m_k = $countones(act);
        end
        cyc++;
        @(negedge clk);
        e = q.pop_front();
        if (slot_load[3]) n_load3++;
        total++;
        if (slot_load !== e.load) begin
            bad++; $display("FAIL slot_load hpos=%0d got=%b want=%b", e.h, slot_load, e.load);
        end
        total++;
        if (done !== e.done) begin
            bad++; $display("FAIL done hpos=%0d got=%b want=%b", e.h, done, e.done);
        end
        total++;
        if (busy !== e.busy) begin
            bad++; $display("FAIL busy hpos=%0d got=%b want=%b", e.h, busy, e.busy);
        end
        total++;
        if (overrun !== e.ovr) begin
            bad++; $display("FAIL overrun hpos=%0d got=%b want=%b", e.h, overrun, e.ovr);
        end
        if (e.chk_slot) begin
            total++;
            if (cur_slot !== e.cur || rom_yofs !== e.yofs) begin
                bad++;
                $display("FAIL cur_slot/rom_yofs hpos=%0d got=%0d/%h want=%0d/%h",
                         e.h, cur_slot, rom_yofs, e.cur, e.yofs);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; hpos = 9'd100; slot_active = '1;
        slot_yofs = 20'h43210;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (slot_load !== '0 || busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0) begin
            bad++; $display("FAIL reset_outputs got load=%b busy=%b done=%b ovr=%b want 0/0/0/0",
                            slot_load, busy, done, overrun);
        end
        total++;
        if (cur_slot !== 3'd0 || rom_yofs !== 4'h0) begin
            bad++; $display("FAIL reset_slot got cur=%0d yofs=%h want 0/0", cur_slot, rom_yofs);
        end
        drive(101, '1, 1'b0);
    endtask

    task automatic test_all_active();
        for (int h = 250; h <= 300; h++) drive(h, 5'b11111, 1'b0);
    endtask

    task automatic test_sparse();
        for (int h = 250; h <= 300; h++) drive(h, 5'b10100, 1'b0);
    endtask

    task automatic test_none();
        for (int h = 250; h <= 270; h++) drive(h, 5'b00000, 1'b0);
    endtask

    task automatic test_yofs_latch();
        slot_yofs = 20'h5A555;
        n_load3 = 0;
        for (int h = 250; h <= 300; h++)
            drive(h, (h >= 260) ? 5'b10111 : 5'b11111, 1'b0);
        total++;
        if (n_load3 !== LC) begin
            bad++; $display("FAIL load3_cycles got=%0d want=%0d", n_load3, LC);
        end
    endtask

    task automatic test_abort();
        for (int h = 250; h <= 263; h++) drive(h, 5'b11111, 1'b0);
        drive(0, 5'b11111, 1'b0);
        for (int h = 1; h <= 20; h++) drive(h, 5'b11111, 1'b0);
        for (int h = 250; h <= 300; h++) drive(h, 5'b11111, 1'b0);
        total++;
        if (overrun !== 1'b1) begin
            bad++; $display("FAIL overrun_sticky got=%b want=1", overrun);
        end
    endtask

    task automatic test_reset_mid();
        for (int h = 250; h <= 268; h++) drive(h, 5'b11111, 1'b0);
        drive(269, 5'b11111, 1'b1);
        drive(270, 5'b11111, 1'b0);
        total++;
        if (cur_slot !== 3'd0) begin
            bad++; $display("FAIL reset_mid_cur got=%0d want=0", cur_slot);
        end
        for (int h = 271; h <= 300; h++) drive(h, 5'b11111, 1'b0);
    endtask

    initial begin
        test_reset();
        test_all_active();
        test_sparse();
        test_none();
        test_yofs_latch();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
